// File: rtl/switch_debouncer_pkg.sv
// Shared board constants for the UW-ID front end.
// Debounce default is derived from the board clock and the debounce window.
package switch_debouncer_pkg;

  localparam int unsigned CLK_HZ              = 50_000_000;
  localparam int unsigned DEBOUNCE_MS         = 20;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = CLK_HZ / 1000 * DEBOUNCE_MS;

endpackage

// File: rtl/switch_debouncer_debounce_bit.sv
// One debounced input: 2-flop synchronizer, hold counter and stable level flop.
// accept is high on the cycle whose clock edge loads the new stable level.
module debounce_bit
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = 20,
  parameter logic        RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic stable,
  output logic accept
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= RESET_VAL;
      sync2_q <= RESET_VAL;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end

  // Any return to the stable level clears the count; no partial credit survives.
  always_comb begin
    accept   = 1'b0;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CntMax) begin
        accept   = 1'b1;
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= RESET_VAL;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces the slide switches and KEY0, and captures a 4-bit digit on each
// debounced KEY0 press together with a one-cycle valid strobe.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned NUM_SW          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_SW-1:0] sw_raw,
  input  logic              key_raw_n,
  output logic [NUM_SW-1:0] sw_stable,
  output logic              key_pressed,
  output logic [3:0]        digit_q,
  output logic              digit_valid
);

  logic [NUM_SW-1:0] sw_accept_unused;
  logic              key_stable_n;
  logic              key_accept;
  logic              press;
  logic              digit_valid_q;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .RESET_VAL      (1'b0)
    ) u_sw (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (sw_raw[i]),
      .stable (sw_stable[i]),
      .accept (sw_accept_unused[i])
    );
  end

  debounce_bit #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .RESET_VAL      (1'b1)
  ) u_key (
    .clk    (clk),
    .reset_n(reset_n),
    .din    (key_raw_n),
    .stable (key_stable_n),
    .accept (key_accept)
  );

  assign key_pressed = ~key_stable_n;

  // Stable level currently released (1) and about to flip: the strobe lands on the
  // same edge that raises key_pressed, and digit_q sees the pre-update sw_stable.
  assign press = key_accept & key_stable_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit_q       <= 4'h0;
      digit_valid_q <= 1'b0;
    end else begin
      digit_valid_q <= press;
      if (press) begin
        digit_q <= 4'(sw_stable);
      end
    end
  end

  assign digit_valid = digit_valid_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench: stimulus queues expected digit/cycle pairs, a negedge monitor
// pops and compares them against every digit_valid strobe.
module tb_switch_debouncer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] sw_raw;
  logic       key_raw_n;
  logic [3:0] sw_stable;
  logic       key_pressed;
  logic [3:0] digit_q;
  logic       digit_valid;

  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    logic [3:0]  digit;
    int unsigned at;
  } exp_t;

  exp_t sb[$];

  switch_debouncer #(
    .NUM_SW         (4),
    .DEBOUNCE_CYCLES(8),
    .CNT_W          (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sw_raw     (sw_raw),
    .key_raw_n  (key_raw_n),
    .sw_stable  (sw_stable),
    .key_pressed(key_pressed),
    .digit_q    (digit_q),
    .digit_valid(digit_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raw change applied just after edge k becomes a strobe on edge k+10.
  task automatic expect_strobe(input logic [3:0] d);
    exp_t e;
    e.digit = d;
    e.at    = cyc + 10;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (digit_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got digit_valid=1 digit_q=%0h at cycle %0d, required 0",
                 digit_q, cyc);
      end else begin
        e = sb.pop_front();
        check("strobe_digit", 32'(digit_q), 32'(e.digit));
        check("strobe_cycle", cyc, e.at);
      end
    end else if (sb.size() > 0 && cyc > sb[0].at) begin
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL missed_strobe: got no strobe by cycle %0d, required one at %0d digit %0h",
               cyc, e.at, e.digit);
    end
  end

  initial begin
    reset_n   = 1'b0;
    sw_raw    = 4'hF;
    key_raw_n = 1'b1;

    // 1: reset values, then release with switches held high
    tick(3);
    check("rst_sw_stable", 32'(sw_stable), 32'h0);
    check("rst_key_pressed", 32'(key_pressed), 32'h0);
    check("rst_digit_q", 32'(digit_q), 32'h0);
    check("rst_digit_valid", 32'(digit_valid), 32'h0);
    reset_n = 1'b1;
    tick(9);
    check("sw_before_latency", 32'(sw_stable), 32'h0);
    tick(1);
    check("sw_at_latency", 32'(sw_stable), 32'hF);

    sw_raw = 4'h0;
    tick(12);
    check("sw_back_to_zero", 32'(sw_stable), 32'h0);

    // 2: five-cycle glitch on one switch is rejected
    sw_raw[1] = 1'b1;
    tick(5);
    sw_raw[1] = 1'b0;
    tick(20);
    check("glitch_rejected", 32'(sw_stable), 32'h0);

    // 3: bouncing key, then a firm press
    for (int i = 0; i < 10; i++) begin
      key_raw_n = ~key_raw_n;
      tick(3);
    end
    key_raw_n = 1'b0;
    expect_strobe(4'h0);
    tick(15);
    check("bounce_key_held", 32'(key_pressed), 32'h1);
    key_raw_n = 1'b1;
    tick(15);
    check("bounce_key_released", 32'(key_pressed), 32'h0);

    // 4: capture, then a long hold with no repeat strobe
    sw_raw = 4'b0010;
    tick(12);
    key_raw_n = 1'b0;
    expect_strobe(4'b0010);
    tick(50);
    check("hold_key_pressed", 32'(key_pressed), 32'h1);
    check("hold_digit_q", 32'(digit_q), 32'h2);
    key_raw_n = 1'b1;
    tick(15);
    check("release_key", 32'(key_pressed), 32'h0);

    // 5: switch and key accepted on the same edge: old switch value captured
    sw_raw    = 4'b1001;
    key_raw_n = 1'b0;
    expect_strobe(4'b0010);
    tick(15);
    check("simul_sw_stable", 32'(sw_stable), 32'h9);
    key_raw_n = 1'b1;
    tick(15);
    key_raw_n = 1'b0;
    expect_strobe(4'b1001);
    tick(15);
    key_raw_n = 1'b1;
    tick(15);

    // 6: reset at count 5 of a press, key still held after release
    key_raw_n = 1'b0;
    tick(7);
    reset_n = 1'b0;
    tick(2);
    check("midrst_key_pressed", 32'(key_pressed), 32'h0);
    check("midrst_digit_q", 32'(digit_q), 32'h0);
    reset_n = 1'b1;
    expect_strobe(4'h0);
    tick(15);
    check("postrst_key_pressed", 32'(key_pressed), 32'h1);
    check("postrst_sw_stable", 32'(sw_stable), 32'h9);
    key_raw_n = 1'b1;
    tick(20);

    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
